// File: rtl/excl_grant_if.sv
// excl_grant_if: request/grant bundle between requesters and excl_grant_ctrl.
// master: requester side (drives requests, observes grants).
// slave:  controller side (observes requests, drives grants).
interface excl_grant_if;
  logic req_a;
  logic req_b;
  logic req_c;
  logic signal_a;
  logic signal_b;
  logic signal_c;

  modport master (
    output req_a, req_b, req_c,
    input  signal_a, signal_b, signal_c
  );

  modport slave (
    input  req_a, req_b, req_c,
    output signal_a, signal_b, signal_c
  );
endinterface

// File: rtl/excl_grant_ctrl.sv
// excl_grant_ctrl: arbitrates between an A side and a BC side so that signal_a is
// never high together with signal_b/signal_c. Contested phases are bounded to
// MAX_HOLD cycles, and each side change passes through GAP_CYCLES all-low cycles
// plus one IDLE cycle. All grants are registered and cleared asynchronously by rst.
// Optional checks: define EXCL_GRANT_ASSERT_EN to compile in p_a_exclusive and p_gap.
module excl_grant_ctrl #(
  parameter int unsigned MAX_HOLD   = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input logic         clk,
  input logic         rst,
  excl_grant_if.slave bus
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam int unsigned GapW  = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GRANT_A  = 2'd1;
  localparam logic [1:0] GRANT_BC = 2'd2;
  localparam logic [1:0] GAP      = 2'd3;

  localparam logic SIDE_A  = 1'b1;
  localparam logic SIDE_BC = 1'b0;

  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);
  localparam logic [GapW-1:0]  GapMax  = GapW'(GAP_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  logic             last_side_q, last_side_d;
  logic             sig_a_q, sig_a_d;
  logic             sig_b_q, sig_b_d;
  logic             sig_c_q, sig_c_d;

  logic req_bc;
  assign req_bc = bus.req_b | bus.req_c;

  // Next-state, counter and grant computation; grants are only ever set in
  // the GRANT state of their own side, which is what guarantees exclusivity.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    last_side_d = last_side_q;
    sig_a_d     = 1'b0;
    sig_b_d     = 1'b0;
    sig_c_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_a && (!req_bc || last_side_q == SIDE_BC)) begin
          state_d     = GRANT_A;
          hold_cnt_d  = HoldW'(1);
          last_side_d = SIDE_A;
          sig_a_d     = 1'b1;
        end else if (req_bc) begin
          state_d     = GRANT_BC;
          hold_cnt_d  = HoldW'(1);
          last_side_d = SIDE_BC;
          sig_b_d     = bus.req_b;
          sig_c_d     = bus.req_c;
        end
      end
      GRANT_A: begin
        if (!bus.req_a || (hold_cnt_q == HoldMax && req_bc)) begin
          state_d   = GAP;
          gap_cnt_d = GapW'(1);
        end else begin
          sig_a_d = 1'b1;
          if (hold_cnt_q != HoldMax) hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      GRANT_BC: begin
        if (!req_bc || (hold_cnt_q == HoldMax && bus.req_a)) begin
          state_d   = GAP;
          gap_cnt_d = GapW'(1);
        end else begin
          sig_b_d = bus.req_b;
          sig_c_d = bus.req_c;
          if (hold_cnt_q != HoldMax) hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == GapMax) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered grants; last_side resets to BC so A wins the first contest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      last_side_q <= SIDE_BC;
      sig_a_q     <= 1'b0;
      sig_b_q     <= 1'b0;
      sig_c_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      last_side_q <= last_side_d;
      sig_a_q     <= sig_a_d;
      sig_b_q     <= sig_b_d;
      sig_c_q     <= sig_c_d;
    end
  end

  assign bus.signal_a = sig_a_q;
  assign bus.signal_b = sig_b_q;
  assign bus.signal_c = sig_c_q;

`ifdef EXCL_GRANT_ASSERT_EN
  logic        any_grant;
  logic        seen_q;
  logic        prev_side_q;
  logic [31:0] low_run_q;

  assign any_grant = sig_a_q | sig_b_q | sig_c_q;

  // Track the side of the most recent grant and the run of all-low cycles since.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q      <= 1'b0;
      prev_side_q <= SIDE_BC;
      low_run_q   <= '0;
    end else if (any_grant) begin
      seen_q      <= 1'b1;
      prev_side_q <= sig_a_q;
      low_run_q   <= '0;
    end else if (low_run_q != 32'hFFFF_FFFF) begin
      low_run_q <= low_run_q + 32'd1;
    end
  end

  p_a_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(bus.signal_a && (bus.signal_b || bus.signal_c)))
    else $error("p_a_exclusive violated");

  p_gap: assert property (@(posedge clk) disable iff (rst)
    (seen_q && any_grant && (sig_a_q != prev_side_q)) |-> (low_run_q >= 32'(GAP_CYCLES)))
    else $error("p_gap violated");
`endif

endmodule

// File: tb/tb_excl_grant_ctrl.sv
// tb_excl_grant_ctrl: directed vectors with hand-computed grant sequences for
// MAX_HOLD=4, GAP_CYCLES=1. Inputs change on the falling edge; grants are
// checked on the following falling edge, i.e. one rising edge later.
module tb_excl_grant_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  excl_grant_if bus ();

  excl_grant_ctrl #(
    .MAX_HOLD  (4),
    .GAP_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] grants();
    return {bus.signal_a, bus.signal_b, bus.signal_c};
  endfunction

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got abc=%b expected abc=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input logic [2:0] req);
    bus.req_a = req[2];
    bus.req_b = req[1];
    bus.req_c = req[0];
  endtask

  // Apply {req_a,req_b,req_c}, pass one rising edge, check grants and exclusivity.
  task automatic step(input string tag, input logic [2:0] req, input logic [2:0] exp);
    logic [2:0] g;
    set_req(req);
    @(negedge clk);
    g = grants();
    check(tag, g, exp);
    check({tag, "_excl"}, {2'b00, g[2] & (g[1] | g[0])}, 3'b000);
  endtask

  // Synchronous-looking reset pulse spanning one rising edge, ending on a falling edge.
  task automatic do_reset();
    set_req(3'b000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [2:0] contest_exp [14];
  logic [2:0] sweep_exp   [16];

  initial begin
    n_chk = 0;
    n_bad = 0;

    contest_exp = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b010,
                    3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b100, 3'b100};
    sweep_exp   = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b010, 3'b011, 3'b011,
                    3'b000, 3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000};

    // Reset with all requests high: grants low before any clock edge.
    rst = 1'b1;
    set_req(3'b111);
    #2;
    check("rst_async", grants(), 3'b000);
    @(negedge clk);
    check("rst_held", grants(), 3'b000);
    set_req(3'b000);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step("idle", 3'b000, 3'b000);

    // Solo A for 3 cycles, then release and turnaround.
    for (int i = 0; i < 3; i++) step("solo_a", 3'b100, 3'b100);
    step("solo_a_rel", 3'b000, 3'b000);
    step("solo_a_gap", 3'b000, 3'b000);

    // Contest from fresh reset: A 4, low 2, B 4, low 2, A ...
    do_reset();
    for (int i = 0; i < 14; i++) step("contest", 3'b110, contest_exp[i]);

    // BC overlap with single-channel tracking, then A arrives mid-phase.
    do_reset();
    step("bc_both", 3'b011, 3'b011);
    step("bc_conly", 3'b001, 3'b001);
    step("bc_both2", 3'b011, 3'b011);
    step("bc_a_arr", 3'b111, 3'b011);
    step("bc_drop", 3'b111, 3'b000);
    step("bc_idle", 3'b111, 3'b000);
    step("bc_to_a", 3'b111, 3'b100);

    // Reset pulsed between edges during GRANT_A.
    #1 rst = 1'b1;
    #1 check("rst_mid", grants(), 3'b000);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_regrant", grants(), 3'b100);

    // Sweep of all request patterns, each held 2 cycles.
    do_reset();
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < 2; k++) step("sweep", 3'(v), sweep_exp[2 * v + k]);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
